// File: rtl/sap_pkg.sv
// Shared types and sizing helpers for the SAP datapath blocks.
package sap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int SAP_WIDTH = 8;

  // Bits needed for a counter that runs 0 .. w-1; never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_hs.sv
// Gate-level half-subtractor: difference and borrow for X - Y.
module hs (
  input  logic x_i,
  input  logic y_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = x_i ^ y_i;
  assign bo_o = ~x_i & y_i;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor DIFF = A - B, LSB first, one bit per clock.
// Two half-subtractors plus an OR form the full-subtract cell.
//
// state  | meaning
// IDLE   | waiting for START; operands captured on an accepted START
// SHIFT  | one difference bit per cycle, WIDTH cycles
// FINISH | DONE high, result and flags valid
module serial_subtractor
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             d_ab, bo_ab, d_bit, bo_bin, bout;
  logic [WIDTH-1:0] res_all;

  hs u_hs_ab (
    .x_i  (a_q[0]),
    .y_i  (b_q[0]),
    .d_o  (d_ab),
    .bo_o (bo_ab)
  );

  hs u_hs_bin (
    .x_i  (d_ab),
    .y_i  (bin_q),
    .d_o  (d_bit),
    .bo_o (bo_bin)
  );

  assign bout = bo_ab | bo_bin;

  // Only WIDTH-1 bits need storing; the final bit goes straight to DIFF.
  assign res_all = {d_bit, res_q};

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == SHIFT);
    done_o   = (state_q == FINISH);
    diff_o   = diff_q;
    borrow_o = borrow_q;
    ovf_o    = ovf_q;
    zero_o   = zero_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          bin_d   = 1'b0;
          cnt_d   = '0;
          a_msb_d = a_i[WIDTH-1];
          b_msb_d = b_i[WIDTH-1];
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_all[WIDTH-1:1];
        bin_d = bout;
        cnt_d = cnt_q + CW'(1);
        // Flags are committed on the last bit so they are valid during FINISH.
        if (cnt_q == CNT_LAST) begin
          diff_d   = res_all;
          borrow_d = bout;
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          zero_d   = (res_all == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus multi-cycle corner sequences.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       busy, done, borrow, ovf, zero;
  logic [7:0] diff;

  int total = 0;
  int bad   = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[8];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk_i    (clk),
    .clr_n_i  (clr_n),
    .start_i  (start),
    .a_i      (a_in),
    .b_i      (b_in),
    .busy_o   (busy),
    .done_o   (done),
    .diff_o   (diff),
    .borrow_o (borrow),
    .ovf_o    (ovf),
    .zero_o   (zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) begin
      bad++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
    end
    if (done && prev_done) begin
      bad++;
      $display("FAIL done_consecutive: done high two cycles in a row");
    end
    prev_done = done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Pulse START for one cycle, scramble the operands afterwards, then wait for DONE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int busy_cnt, output int done_cyc);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    busy_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a_in  = ~a;
        b_in  = 8'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int bc, dc, ndone, first_done;
    int dcyc[$];
    logic [7:0] ddiff[$];

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1, 1'b0};

    // Reset with START asserted: reset must win.
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_diff",   32'(diff),   32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf",    32'(ovf),    32'd0);
    chk("rst_zero",   32'(zero),   32'd0);
    start = 1'b0;
    clr_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, bc, dc);
      chk($sformatf("v%0d busy_cycles", i), 32'(bc), 32'd8);
      chk($sformatf("v%0d done_cycle", i), 32'(dc), 32'd9);
      chk($sformatf("v%0d diff", i), 32'(diff), 32'(vecs[i].diff));
      chk($sformatf("v%0d borrow", i), 32'(borrow), 32'(vecs[i].borrow));
      chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].zero));
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d diff_held", i), 32'(diff), 32'(vecs[i].diff));
    end

    // START pulsed mid-operation is ignored.
    @(negedge clk);
    start = 1'b1; a_in = 8'h3C; b_in = 8'h3C;
    ndone = 0; first_done = -1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) begin a_in = 8'h10; b_in = 8'h01; end
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
    end
    start = 1'b0;
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_done_cycle", 32'(first_done), 32'd9);
    chk("ign_diff", 32'(diff), 32'h00);
    chk("ign_zero", 32'(zero), 32'd1);

    // Reset in the 4th BUSY cycle discards the operation.
    @(negedge clk);
    start = 1'b1; a_in = 8'h09; b_in = 8'h04;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_busy_before", 32'(busy), 32'd1);
    clr_n = 1'b0;
    @(negedge clk);
    chk("mid_busy",   32'(busy),   32'd0);
    chk("mid_done",   32'(done),   32'd0);
    chk("mid_diff",   32'(diff),   32'd0);
    chk("mid_borrow", 32'(borrow), 32'd0);
    chk("mid_ovf",    32'(ovf),    32'd0);
    chk("mid_zero",   32'(zero),   32'd0);
    clr_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mid_no_activity", 32'(ndone), 32'd0);
    do_op(8'h09, 8'h04, bc, dc);
    chk("mid_fresh_done_cycle", 32'(dc), 32'd9);
    chk("mid_fresh_diff", 32'(diff), 32'h05);
    chk("mid_fresh_borrow", 32'(borrow), 32'd0);

    // START held high: one result every 10 cycles.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a_in = 8'h0A; b_in = 8'h01;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        dcyc.push_back(c);
        ddiff.push_back(diff);
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(dcyc.size()), 32'd3);
    foreach (dcyc[k]) begin
      chk($sformatf("held_done_cycle%0d", k), 32'(dcyc[k]), 32'(9 + 10 * k));
      chk($sformatf("held_diff%0d", k), 32'(ddiff[k]), 32'h09);
    end
    repeat (3) @(negedge clk);
    chk("held_released_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor computing DIFF = A - B, one bit per clock, LSB first.
- Built around a gate-level half-subtractor cell and a borrow flip-flop.
- It is the subtract counterpart to the adder building blocks. It serves as a compact ALU option for the SAP datapath, where area matters more than latency.
- A START/BUSY/DONE handshake connects it to the controller-sequencer.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
CLK     input   1       rising-edge clock
CLR_N   input   1       synchronous active-low reset
START   input   1       request; sampled only in IDLE
A       input   WIDTH   minuend; captured on accepted START
B       input   WIDTH   subtrahend; captured on accepted START
BUSY    output  1       high while in SHIFT state
DONE    output  1       one-cycle pulse when result is valid
DIFF    output  WIDTH   A - B mod 2^WIDTH; held until next accepted START
BORROW  output  1       1 when A < B unsigned (final borrow-out)
OVF     output  1       signed overflow: A[msb] != B[msb] and DIFF[msb] != A[msb]
ZERO    output  1       DIFF == 0

Behaviour:
- Interface: one clock CLK. Reset CLR_N is synchronous and active-low, sampled on the CLK rising edge; no asynchronous path.
- Reset (CLR_N=0 at an edge) puts the block in IDLE and clears all outputs to 0: BUSY, DONE, DIFF, BORROW, OVF, ZERO. ZERO is cleared to 0 even though DIFF=0. Reset overrides all other inputs, including mid-operation; a partial result is discarded.
- FSM has three states: IDLE, SHIFT, FINISH.
- IDLE:
  - START=1 captures A and B into shift registers.
  - The borrow FF and bit counter are cleared.
  - DIFF, BORROW, OVF and ZERO are not modified at this point; they keep their previous values until FINISH.
  - Next state is SHIFT.
  - START=0 keeps the block in IDLE.
- SHIFT, each cycle:
  - Diff bit = a0 ^ b0 ^ bin.
  - Borrow-out = (~a0 & b0) | (~(a0 ^ b0) & bin), formed from two half-subtractors plus an OR.
  - The diff bit shifts into the result register from the MSB side; A and B shift right.
  - The borrow FF takes the borrow-out; the counter increments.
  - After WIDTH cycles (counter == WIDTH-1 at the edge), next state is FINISH.
- FINISH, one cycle:
  - DONE=1. DIFF, BORROW, OVF and ZERO are updated with the new result, valid in the same cycle DONE is high.
  - Original A[msb] and B[msb] are latched at capture for OVF.
  - Next state is IDLE.
- Latency: accepted START at edge 0 → BUSY high in cycles 1..WIDTH → DONE high in cycle WIDTH+1. Back-to-back throughput is one result per WIDTH+2 cycles.
- START while BUSY or in FINISH is ignored; no queueing. A START held high continuously restarts on the first IDLE cycle after FINISH.
- A and B may change freely after capture without affecting the result.
- Boundary cases:
  - A == B gives DIFF=0, ZERO=1, BORROW=0.
  - 0 - max gives DIFF=1, BORROW=1.
  - Most-negative minus 1 gives OVF=1.
- DONE is never high in consecutive cycles. BUSY and DONE are never high together.

Decomposition:
- Package sap_pkg holds:
  - state_t enum {IDLE, SHIFT, FINISH}
  - localparam SAP_WIDTH = 8, used as the WIDTH default
  - a function clog2-based counter width helper
- Sub-module hs (half-subtractor, gate-level: D = X ^ Y, Bo = ~X & Y). It is instantiated twice to form the full-subtract cell, and the two borrows are combined with an OR gate.
- The FSM, shift registers and flags stay in serial_subtractor.

Test Plan:
- Reset, then A=8'h05, B=8'h03, START one cycle → BUSY high 8 cycles; DONE pulse in cycle 9 with DIFF=8'h02, BORROW=0, OVF=0, ZERO=0.
- A=8'h03, B=8'h05 → DIFF=8'hFE, BORROW=1, OVF=0; A=8'h00, B=8'hFF → DIFF=8'h01, BORROW=1.
- A=8'h80, B=8'h01 → DIFF=8'h7F, OVF=1, BORROW=0; A=8'h7F, B=8'hFF → DIFF=8'h80, OVF=1.
- A=8'h3C, B=8'h3C → DIFF=8'h00, ZERO=1.
  - Then START with A=8'h10, B=8'h01 pulsed in cycle 3 of BUSY → ignored, no extra DONE, DIFF still 8'h00.
- Start 8'h09-8'h04 and assert CLR_N=0 in cycle 4 of BUSY → next cycle IDLE, all outputs 0, no DONE.
  - A fresh START after release yields the correct result 8'h05.
- START held high for 30 cycles with A=8'h0A, B=8'h01 → DONE pulses every 10 cycles with DIFF=8'h09 each time.
